// File: rtl/rom_loader_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : rom_loader_pkg                                                  |
// | Desc     : Shared state encoding and ioctl address width for rom_loader.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package rom_loader_pkg;

  localparam int unsigned c_ioctl_aw = 25;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } rom_ld_state_t;

endpackage

`default_nettype wire

// File: rtl/rom_hold_timer.sv
// +----------------------------------------------------------------------------+
// | Module   : rom_hold_timer                                                  |
// | Desc     : Loadable down-counter with a zero flag; stops at zero.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module rom_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/rom_loader.sv
// +----------------------------------------------------------------------------+
// | Module   : rom_loader                                                      |
// | Desc     : hps_io byte-stream ROM loader with core reset hold and image    |
// |            completeness check. ROM_LOADER_CHECKSUM_EN adds a byte-sum      |
// |            output and an EXP_SUM match condition for a good image.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int ROM_BYTES   = 147456,
  parameter int INDEX       = 0,
  parameter int HOLD_CYCLES = 16
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  parameter logic [15:0] EXP_SUM = 16'h0000
`endif
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [c_ioctl_aw-1:0] ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  input  logic [15:0]           ioctl_index,
  output logic [ADDR_W-1:0]     dn_addr,
  output logic [7:0]            dn_data,
  output logic                  dn_wr,
  output logic                  core_reset,
  output logic                  rom_ok,
  output logic                  rom_err,
  output logic [ADDR_W:0]       byte_count
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  localparam logic [c_ioctl_aw:0] c_rom_lim   = (c_ioctl_aw + 1)'(ROM_BYTES);
  localparam logic [ADDR_W:0]     c_rom_cnt   = (ADDR_W + 1)'(ROM_BYTES);
  localparam logic [15:0]         c_index     = 16'(INDEX);
  localparam logic [7:0]          c_hold_init = 8'(HOLD_CYCLES - 1);

  rom_ld_state_t state_q;
  rom_ld_state_t state_d;

  logic [ADDR_W-1:0] dn_addr_q;
  logic [7:0]        dn_data_q;
  logic              dn_wr_q;
  logic [ADDR_W:0]   byte_count_q;
  logic              oob_q;
  logic              rom_ok_q;
  logic              rom_err_q;

  logic w_sel;
  logic w_wr_hit;
  logic w_in_range;
  logic w_accept;
  logic w_oob_hit;
  logic w_enter_load;
  logic w_image_good;
  logic w_hold_load;
  logic w_hold_dec;
  logic w_hold_zero;

  assign w_sel        = ioctl_download && (ioctl_index == c_index);
  // The write in the cycle download falls is still in LOAD, so it is accepted.
  assign w_wr_hit     = (state_q == LOAD) && ioctl_wr && (ioctl_index == c_index);
  assign w_in_range   = ({1'b0, ioctl_addr} < c_rom_lim);
  assign w_accept     = w_wr_hit && w_in_range;
  assign w_oob_hit    = w_wr_hit && !w_in_range;
  assign w_enter_load = w_sel && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;

  assign w_image_good = (byte_count_q == c_rom_cnt) && !oob_q && (checksum_q == EXP_SUM);

  always_ff @(posedge clk_sys) begin
    if (reset || w_enter_load) begin
      checksum_q <= 16'h0000;
    end else if (w_accept) begin
      checksum_q <= checksum_q + {8'h00, ioctl_dout};
    end
  end

  assign checksum = checksum_q;
`else
  assign w_image_good = (byte_count_q == c_rom_cnt) && !oob_q;
`endif

  always_comb begin
    state_d     = state_q;
    w_hold_load = 1'b0;
    w_hold_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (w_sel) state_d = LOAD;
      end
      LOAD: begin
        if (!ioctl_download) begin
          state_d     = HOLD;
          w_hold_load = 1'b1;
        end
      end
      HOLD: begin
        if (w_hold_zero) begin
          state_d = w_image_good ? DONE : ERR;
        end else begin
          w_hold_dec = 1'b1;
        end
      end
      DONE, ERR: begin
        if (w_sel) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  rom_hold_timer #(
    .W (8)
  ) u_hold_timer (
    .clk_i      (clk_sys),
    .rst_i      (reset),
    .load_i     (w_hold_load),
    .load_val_i (c_hold_init),
    .dec_i      (w_hold_dec),
    .zero_o     (w_hold_zero)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dn_addr_q    <= '0;
      dn_data_q    <= 8'h00;
      dn_wr_q      <= 1'b0;
      byte_count_q <= '0;
      oob_q        <= 1'b0;
      rom_ok_q     <= 1'b0;
      rom_err_q    <= 1'b0;
    end else begin
      dn_wr_q <= w_accept;
      if (w_accept) begin
        dn_addr_q <= ioctl_addr[ADDR_W-1:0];
        dn_data_q <= ioctl_dout;
      end
      if (w_enter_load) begin
        byte_count_q <= '0;
        oob_q        <= 1'b0;
        rom_ok_q     <= 1'b0;
        rom_err_q    <= 1'b0;
      end else begin
        if (w_accept && (byte_count_q != '1)) begin
          byte_count_q <= byte_count_q + (ADDR_W + 1)'(1);
        end
        if (w_oob_hit) begin
          oob_q <= 1'b1;
        end
        if ((state_q == HOLD) && w_hold_zero) begin
          rom_ok_q  <= w_image_good;
          rom_err_q <= !w_image_good;
        end
      end
    end
  end

  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_wr      = dn_wr_q;
  assign byte_count = byte_count_q;
  assign rom_ok     = rom_ok_q;
  assign rom_err    = rom_err_q;
  assign core_reset = reset || (state_q == IDLE) || (state_q == LOAD) || (state_q == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_rom_loader                                                   |
// | Desc     : Self-checking bench for rom_loader (16-byte image, 4-cycle tail)|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rom_loader;

  localparam int ADDR_W      = 18;
  localparam int ROM_BYTES   = 16;
  localparam int INDEX       = 0;
  localparam int HOLD_CYCLES = 4;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [15:0]       ioctl_index;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wr;
  logic              core_reset;
  logic              rom_ok;
  logic              rom_err;
  logic [ADDR_W:0]   byte_count;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  rom_loader #(
    .ADDR_W      (ADDR_W),
    .ROM_BYTES   (ROM_BYTES),
    .INDEX       (INDEX),
    .HOLD_CYCLES (HOLD_CYCLES)
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    .EXP_SUM     (16'h0FF0)
`endif
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .core_reset     (core_reset),
    .rom_ok         (rom_ok),
    .rom_err        (rom_err),
    .byte_count     (byte_count)
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    .checksum       (checksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  // Write list for one download session
  int         q_addr[$];
  logic [7:0] q_data[$];
  int         q_idx[$];
  int         q_gap[$];

  // Reference results of the last session
  int          m_cnt;
  bit          m_oob;
  logic [15:0] m_sum;
  int          m_rel;
  bit          m_loaded;

  typedef struct {
    string name;
    int    nwr;
    int    oob_at;
    int    dl_idx;
    bit    fall_wr;
    bit    ff_data;
    bit    exp_ok;
    bit    exp_err;
    int    exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = 8'h00;
    ioctl_index    = 16'h0000;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic clear_list();
    q_addr.delete();
    q_data.delete();
    q_idx.delete();
    q_gap.delete();
  endtask

  task automatic push_wr(input int a, input logic [7:0] d, input int idx, input int gap);
    q_addr.push_back(a);
    q_data.push_back(d);
    q_idx.push_back(idx);
    q_gap.push_back(gap);
  endtask

  // One download session: entry cycle, writes, fall, then wait for core release.
  task automatic run_download(input int dl_idx, input bit last_on_fall, input bit hold_poke);
    int  n;
    bit  acc;
    m_cnt    = 0;
    m_oob    = 1'b0;
    m_sum    = 16'h0000;
    m_loaded = (dl_idx == INDEX);
    ioctl_download = 1'b1;
    ioctl_index    = 16'(dl_idx);
    ioctl_wr       = 1'b0;
    step();
    chk("dn_wr_entry", dn_wr, 1'b0);
    for (int i = 0; i < q_addr.size(); i++) begin
      for (int g = 0; g < q_gap[i]; g++) begin
        ioctl_wr = 1'b0;
        step();
        chk("dn_wr_gap", dn_wr, 1'b0);
      end
      ioctl_wr    = 1'b1;
      ioctl_addr  = 25'(q_addr[i]);
      ioctl_dout  = q_data[i];
      ioctl_index = 16'(q_idx[i]);
      if (last_on_fall && (i == q_addr.size() - 1)) ioctl_download = 1'b0;
      acc = m_loaded && (q_idx[i] == INDEX) && (q_addr[i] < ROM_BYTES);
      if (m_loaded && (q_idx[i] == INDEX) && (q_addr[i] >= ROM_BYTES)) m_oob = 1'b1;
      if (acc) begin
        m_cnt++;
        m_sum = m_sum + {8'h00, q_data[i]};
      end
      step();
      chk("dn_wr_strobe", dn_wr, acc);
      if (acc) begin
        chk("dn_addr", dn_addr, q_addr[i]);
        chk("dn_data", dn_data, q_data[i]);
      end
    end
    ioctl_wr = 1'b0;
    if (!last_on_fall) begin
      ioctl_download = 1'b0;
      step();
      chk("dn_wr_fall", dn_wr, 1'b0);
    end
    n = 1;
    while (core_reset && (n < 40)) begin
      if (hold_poke && (n == 2)) begin
        ioctl_download = 1'b1;
        ioctl_index    = 16'(INDEX);
        ioctl_wr       = 1'b1;
        ioctl_addr     = '0;
      end else begin
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
      end
      step();
      n++;
      chk("dn_wr_hold", dn_wr, 1'b0);
    end
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    m_rel = core_reset ? -1 : n;
  endtask

  task automatic check_result(input string tag, input bit exp_ok, input bit exp_err, input int exp_cnt);
    bit ok;
    bit err;
    ok  = exp_ok;
    err = exp_err;
`ifdef ROM_LOADER_CHECKSUM_EN
    if (m_loaded) begin
      chk({tag, "_checksum"}, checksum, m_sum);
      if (m_sum != 16'h0FF0) begin
        ok  = 1'b0;
        err = 1'b1;
      end
    end
`endif
    chk({tag, "_release"}, m_rel, m_loaded ? (HOLD_CYCLES + 1) : -1);
    chk({tag, "_rom_ok"}, rom_ok, ok);
    chk({tag, "_rom_err"}, rom_err, err);
    chk({tag, "_byte_count"}, byte_count, exp_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"full",     16, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16};
    vecs[1] = '{"short",    15, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 15};
    vecs[2] = '{"oob",      16,  8, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16};
    vecs[3] = '{"wrongidx", 16, -1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[4] = '{"fall_wr",  16, -1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 16};
    vecs[5] = '{"long",     17, -1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 17};
    vecs[6] = '{"ff_data",  16, -1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 16};

    do_reset();
    chk("rst_dn_addr", dn_addr, 0);
    chk("rst_dn_data", dn_data, 0);
    chk("rst_dn_wr", dn_wr, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_rom_ok", rom_ok, 0);
    chk("rst_rom_err", rom_err, 0);
    chk("rst_core_reset", core_reset, 1);

    // Table-driven sessions, each from a fresh reset
    foreach (vecs[v]) begin
      do_reset();
      clear_list();
      for (int i = 0; i < vecs[v].nwr; i++) begin
        logic [7:0] d;
        d = vecs[v].ff_data ? 8'hFF : (8'(i % 16) ^ 8'hA5);
        push_wr(i % 16, d, vecs[v].dl_idx, 0);
        if (i == vecs[v].oob_at) push_wr(16, 8'h5A, vecs[v].dl_idx, 0);
      end
      run_download(vecs[v].dl_idx, vecs[v].fall_wr, 1'b0);
      check_result(vecs[v].name, vecs[v].exp_ok, vecs[v].exp_err, vecs[v].exp_cnt);
      if (vecs[v].dl_idx != INDEX) chk("wrongidx_core_reset", core_reset, 1);
    end

    // Reset in the middle of a load, then a clean reload
    do_reset();
    ioctl_download = 1'b1;
    ioctl_index    = 16'(INDEX);
    step();
    for (int i = 0; i < 8; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'hFF;
      step();
    end
    chk("midload_count", byte_count, 8);
    reset      = 1'b1;
    ioctl_addr = 25'd8;
    step();
    chk("midrst_dn_wr", dn_wr, 0);
    chk("midrst_byte_count", byte_count, 0);
    chk("midrst_dn_addr", dn_addr, 0);
    chk("midrst_core_reset", core_reset, 1);
    reset          = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    step();
    chk("postrst_core_reset", core_reset, 1);
    clear_list();
    for (int i = 0; i < 16; i++) push_wr(i, 8'hFF, INDEX, 0);
    run_download(INDEX, 1'b0, 1'b1);
    check_result("reload", 1'b1, 1'b0, 16);

    // Randomized back-to-back sessions, starting from DONE/ERR
    for (int r = 0; r < 12; r++) begin
      bit good;
      clear_list();
      good = ($urandom_range(0, 1) == 1);
      if (good) begin
        for (int i = 0; i < 16; i++) push_wr(i, 8'($urandom), INDEX, $urandom_range(0, 2));
      end else begin
        int n;
        n = $urandom_range(12, 18);
        for (int i = 0; i < n; i++) begin
          push_wr($urandom_range(0, 19), 8'($urandom),
                  ($urandom_range(0, 7) == 0) ? 1 : INDEX, $urandom_range(0, 2));
        end
      end
      run_download(INDEX, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_result("random", (m_cnt == ROM_BYTES) && !m_oob,
                   !((m_cnt == ROM_BYTES) && !m_oob), m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
